preif_fetch: RTL and testbench

- Front-end fetch requester that owns the PC. It issues single-beat instruction reads on the instruction-memory request/response interface.
- It drives the post-IF handoff signals (pc, inst, exception type, ren/ok/valid) consumed by the IF→ID pipeline register.
- It generates the fetch stall (stall_i[0] source) and handles branch and exception redirects, including squashing fetches already in flight.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/preif_pc_sel.sv | 33 +++
 rtl/preif_fetch.sv | 195 +++++++++++++++++++
 tb/tb_preif_fetch.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Purpose: shared fetch-side types and constants (FSM states, reset PC, exception bits, stall indices).
// Latency: none, declarations only.
// Backpressure: n/a.
package cpu_pkg;

  // Fetch requester states.
  typedef enum logic [1:0] {
    REQ     = 2'd0,  // request the current pc
    WAIT    = 2'd1,  // request accepted, waiting for data
    HOLD    = 2'd2,  // instruction delivered, downstream stalled
    DISCARD = 2'd3   // a squashed response is still in flight
  } fetch_state_e;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  // Bit positions in the fetch exception type word.
  localparam int ADEL_BIT = 4;

  // Positions in the pipeline stall vector.
  localparam int INST = 0;
  localparam int ID   = 1;
  localparam int EXE  = 2;
  localparam int DATA = 3;

endpackage

// File: rtl/preif_pc_sel.sv
// Purpose: next-PC mux, priority exception > branch > sequential advance > hold.
// Latency: combinational.
// Backpressure: none; the caller decides when to advance.
// Ports: pc_i current pc; exception_i/exception_pc_i and branch_enable_i/branch_target_i
//        redirect sources; advance_i selects pc+4; pc_next_o result; redirect_o any redirect.
module preif_pc_sel
  import cpu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        exception_i,
  input  logic [31:0] exception_pc_i,
  input  logic        branch_enable_i,
  input  logic [31:0] branch_target_i,
  input  logic        advance_i,
  output logic [31:0] pc_next_o,
  output logic        redirect_o
);

  always_comb begin
    pc_next_o = pc_i;
    if (exception_i) begin
      pc_next_o = exception_pc_i;
    end else if (branch_enable_i) begin
      pc_next_o = branch_target_i;
    end else if (advance_i) begin
      // Wraps modulo 2^32 by construction.
      pc_next_o = pc_i + 32'd4;
    end
  end

  assign redirect_o = exception_i | branch_enable_i;

endmodule

// File: rtl/preif_fetch.sv
// Purpose: owns the PC, issues single-beat instruction reads, hands pc/inst/exception to IF->ID.
// Latency: request to delivery is 2 cycles with zero-wait memory (accept, data, registered delivery).
// Backpressure: a downstream stall at delivery parks the FSM in HOLD with outputs frozen; redirects override.
// Ports: clock_i/reset_i (async active-high); branch_*/exception_* redirect inputs; stall_i[3:1]
//        downstream stalls; inst_req_o/inst_addr_o/inst_addr_ok_i request channel;
//        inst_rdata_i/inst_data_ok_i response channel; inst_stall_o fetch-not-complete;
//        postif_* handoff to the IF->ID register.
// Optional: define PREIF_FETCH_PERF_EN to add perf_fetch_cnt_o and perf_squash_cnt_o.
module preif_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int          ADEL_BIT = cpu_pkg::ADEL_BIT
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        branch_enable_i,
  input  logic [31:0] branch_target_i,
  input  logic        exception_i,
  input  logic [31:0] exception_pc_i,
  input  logic [3:0]  stall_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic [31:0] inst_rdata_i,
  input  logic        inst_data_ok_i,
  output logic        inst_stall_o,
`ifdef PREIF_FETCH_PERF_EN
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_squash_cnt_o,
`endif
  output logic [31:0] postif_pc_o,
  output logic [31:0] postif_inst_o,
  output logic [31:0] postif_exception_type_o,
  output logic        postif_inst_ren_o,
  output logic        postif_inst_ok_o,
  output logic        postif_inst_valid_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  out_pc_q, out_pc_d;
  logic [31:0]  out_inst_q, out_inst_d;
  logic [31:0]  out_exc_q, out_exc_d;
  logic         ok_q, ok_d;

  logic         redirect;
  logic         down_stall;
  logic         misaligned;
  logic         advance;
  logic         deliver;
  logic         drop;
  logic [31:0]  inst_sel;
  logic [31:0]  exc_sel;

  // stall_i[INST] is this block's own stall fed back; it carries no information here.
  logic unused_stall_inst;
  assign unused_stall_inst = stall_i[INST];

  assign down_stall = |stall_i[DATA:ID];
  assign misaligned = pc_q[1:0] != 2'b00;

  preif_pc_sel u_pc_sel (
    .pc_i            (pc_q),
    .exception_i     (exception_i),
    .exception_pc_i  (exception_pc_i),
    .branch_enable_i (branch_enable_i),
    .branch_target_i (branch_target_i),
    .advance_i       (advance),
    .pc_next_o       (pc_d),
    .redirect_o      (redirect)
  );

  always_comb begin
    state_d  = state_q;
    advance  = 1'b0;
    deliver  = 1'b0;
    drop     = 1'b0;
    inst_sel = inst_rdata_i;
    exc_sel  = '0;
    case (state_q)
      REQ: begin
        if (redirect) begin
          // An accepted request at the old pc still owes us a response.
          if (!misaligned && inst_addr_ok_i) state_d = DISCARD;
        end else if (misaligned) begin
          // Never touches memory: deliver the address-error marker directly.
          deliver  = 1'b1;
          inst_sel = '0;
          exc_sel  = 32'd1 << ADEL_BIT;
        end else if (inst_addr_ok_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (inst_data_ok_i) begin
          if (redirect) begin
            drop    = 1'b1;
            state_d = REQ;
          end else begin
            deliver = 1'b1;
          end
        end else if (redirect) begin
          state_d = DISCARD;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_d = REQ;
        end else if (!down_stall) begin
          advance = 1'b1;
          state_d = REQ;
        end
      end
      DISCARD: begin
        if (inst_data_ok_i) begin
          drop    = 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase

    if (deliver) begin
      if (down_stall) begin
        state_d = HOLD;
      end else begin
        advance = 1'b1;
        state_d = REQ;
      end
    end
  end

  always_comb begin
    // ok stays up for every cycle spent parked in HOLD.
    ok_d       = deliver | (state_q == HOLD && !redirect && down_stall);
    out_pc_d   = deliver ? pc_q     : out_pc_q;
    out_inst_d = deliver ? inst_sel : out_inst_q;
    out_exc_d  = deliver ? exc_sel  : out_exc_q;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      out_pc_q   <= RESET_PC;
      out_inst_q <= '0;
      out_exc_q  <= '0;
      ok_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      out_pc_q   <= out_pc_d;
      out_inst_q <= out_inst_d;
      out_exc_q  <= out_exc_d;
      ok_q       <= ok_d;
    end
  end

  // reset_i gates the request so the port reads idle while reset is held.
  assign inst_req_o              = !reset_i && state_q == REQ && !misaligned;
  assign inst_addr_o             = inst_req_o ? pc_q : '0;
  assign inst_stall_o            = !ok_q;
  assign postif_pc_o             = out_pc_q;
  assign postif_inst_o           = out_inst_q;
  assign postif_exception_type_o = out_exc_q;
  assign postif_inst_ren_o       = state_q == WAIT || state_q == DISCARD;
  assign postif_inst_ok_o        = ok_q;
  // A delivery that coincides with a redirect is on the wrong path.
  assign postif_inst_valid_o     = ok_q && !redirect;

`ifdef PREIF_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] squash_cnt_q, squash_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + (deliver ? 32'd1 : 32'd0);
    squash_cnt_d = squash_cnt_q + (drop ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fetch_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign perf_fetch_cnt_o  = fetch_cnt_q;
  assign perf_squash_cnt_o = squash_cnt_q;
`endif

endmodule

// File: tb/tb_preif_fetch.sv
// Bench for preif_fetch: transaction-level model plus a bench-side memory, checked every cycle,
// with literal expectations at key points of each directed scenario.
module tb_preif_fetch;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        branch_enable_i;
  logic [31:0] branch_target_i;
  logic        exception_i;
  logic [31:0] exception_pc_i;
  logic [3:0]  stall_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i;
  logic [31:0] inst_rdata_i;
  logic        inst_data_ok_i;
  logic        inst_stall_o;
  logic [31:0] postif_pc_o;
  logic [31:0] postif_inst_o;
  logic [31:0] postif_exception_type_o;
  logic        postif_inst_ren_o;
  logic        postif_inst_ok_o;
  logic        postif_inst_valid_o;
`ifdef PREIF_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_squash_cnt_o;
`endif

  preif_fetch dut (
    .clock_i                 (clock_i),
    .reset_i                 (reset_i),
    .branch_enable_i         (branch_enable_i),
    .branch_target_i         (branch_target_i),
    .exception_i             (exception_i),
    .exception_pc_i          (exception_pc_i),
    .stall_i                 (stall_i),
    .inst_req_o              (inst_req_o),
    .inst_addr_o             (inst_addr_o),
    .inst_addr_ok_i          (inst_addr_ok_i),
    .inst_rdata_i            (inst_rdata_i),
    .inst_data_ok_i          (inst_data_ok_i),
    .inst_stall_o            (inst_stall_o),
`ifdef PREIF_FETCH_PERF_EN
    .perf_fetch_cnt_o        (perf_fetch_cnt_o),
    .perf_squash_cnt_o       (perf_squash_cnt_o),
`endif
    .postif_pc_o             (postif_pc_o),
    .postif_inst_o           (postif_inst_o),
    .postif_exception_type_o (postif_exception_type_o),
    .postif_inst_ren_o       (postif_inst_ren_o),
    .postif_inst_ok_o        (postif_inst_ok_o),
    .postif_inst_valid_o     (postif_inst_valid_o)
  );

  always #5 clock_i = ~clock_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: pc to fetch next, transactions owed by memory (0 none, 1 live, 2 squashed),
  // whether a delivered instruction is parked, and the registered handoff values.
  logic [31:0] m_pc, m_opc, m_oinst, m_oexc;
  int          m_pend;
  bit          m_hold, m_ok, m_nok;
  logic [31:0] m_fetch, m_squash;

  // Memory: grants after grant_lat cycles of request, answers data_lat cycles after grant.
  int          grant_lat, data_lat, req_age, mem_cnt;
  bit          mem_busy;
  logic [31:0] mem_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction

  function automatic bit exp_req();
    return !reset_i && m_pend == 0 && !m_hold && m_pc[1:0] == 2'b00;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'hBFC0_0000; m_opc = 32'hBFC0_0000; m_oinst = '0; m_oexc = '0;
    m_pend = 0; m_hold = 0; m_ok = 0; m_fetch = '0; m_squash = '0;
    mem_busy = 0; req_age = 0; mem_cnt = 0; mem_addr = '0;
    inst_addr_ok_i = 0; inst_data_ok_i = 0; inst_rdata_i = '0;
  endtask

  task automatic mem_drive();
    inst_addr_ok_i = exp_req() && req_age >= grant_lat;
    inst_data_ok_i = mem_busy && mem_cnt == 1;
    inst_rdata_i   = inst_data_ok_i ? mem_word(mem_addr) : 32'hDEAD_BEEF;
  endtask

  task automatic compare();
    bit r;
    r = exp_req();
    chk("req",   32'(inst_req_o),          32'(r));
    chk("addr",  inst_addr_o,              r ? m_pc : 32'h0);
    chk("ren",   32'(postif_inst_ren_o),   32'(m_pend != 0));
    chk("ok",    32'(postif_inst_ok_o),    32'(m_ok));
    chk("stall", 32'(inst_stall_o),        32'(!m_ok));
    chk("valid", 32'(postif_inst_valid_o), 32'(m_ok && !(exception_i || branch_enable_i)));
    chk("pc",    postif_pc_o,              m_opc);
    chk("inst",  postif_inst_o,            m_oinst);
    chk("exc",   postif_exception_type_o,  m_oexc);
`ifdef PREIF_FETCH_PERF_EN
    chk("perf_fetch",  perf_fetch_cnt_o,  m_fetch);
    chk("perf_squash", perf_squash_cnt_o, m_squash);
`endif
  endtask

  task automatic deliver(input logic [31:0] inst, input logic [31:0] exc, input bit dstall);
    m_opc = m_pc; m_oinst = inst; m_oexc = exc; m_nok = 1; m_fetch++;
    if (dstall) m_hold = 1;
    else m_pc = m_pc + 32'd4;
  endtask

  task automatic model_step();
    bit          redir, dstall;
    logic [31:0] tgt;
    redir  = exception_i || branch_enable_i;
    tgt    = exception_i ? exception_pc_i : branch_target_i;
    dstall = stall_i[3:1] != 3'b000;
    m_nok  = 0;
    if (m_hold) begin
      if (redir) begin m_hold = 0; m_pc = tgt; end
      else if (!dstall) begin m_hold = 0; m_pc = m_pc + 32'd4; end
      else m_nok = 1;
    end else if (m_pend == 0) begin
      if (redir) begin
        if (inst_addr_ok_i && m_pc[1:0] == 2'b00) m_pend = 2;
        m_pc = tgt;
      end else if (m_pc[1:0] != 2'b00) deliver(32'h0, 32'h10, dstall);
      else if (inst_addr_ok_i) m_pend = 1;
    end else if (m_pend == 1) begin
      if (inst_data_ok_i) begin
        m_pend = 0;
        if (redir) begin m_squash++; m_pc = tgt; end
        else deliver(inst_rdata_i, 32'h0, dstall);
      end else if (redir) begin
        m_pend = 2; m_pc = tgt;
      end
    end else begin
      if (redir) m_pc = tgt;
      if (inst_data_ok_i) begin m_pend = 0; m_squash++; end
    end
    m_ok = m_nok;
  endtask

  task automatic mem_step(input bit r);
    if (mem_busy) begin
      if (inst_data_ok_i) mem_busy = 0;
      else mem_cnt--;
    end
    if (inst_addr_ok_i) begin mem_busy = 1; mem_cnt = data_lat; mem_addr = m_pc; end
    if (r && !inst_addr_ok_i) req_age++;
    else req_age = 0;
  endtask

  // One clock cycle: drive memory, check at negedge, advance model, resume after posedge.
  task automatic tick();
    bit r;
    mem_drive();
    @(negedge clock_i);
    compare();
    r = exp_req();
    mem_step(r);
    model_step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset_i = 1; branch_enable_i = 0; branch_target_i = '0;
    exception_i = 0; exception_pc_i = '0; stall_i = '0;
    grant_lat = 0; data_lat = 1;
    model_reset();

    // Reset values.
    #12;
    chk("rst_req",   32'(inst_req_o),          32'h0);
    chk("rst_addr",  inst_addr_o,              32'h0);
    chk("rst_stall", 32'(inst_stall_o),        32'h1);
    chk("rst_pc",    postif_pc_o,              32'hBFC0_0000);
    chk("rst_ok",    32'(postif_inst_ok_o),    32'h0);
    chk("rst_ren",   32'(postif_inst_ren_o),   32'h0);
    chk("rst_valid", 32'(postif_inst_valid_o), 32'h0);
    @(negedge clock_i); reset_i = 0;
    @(posedge clock_i); #1;

    // Zero-wait streaming.
    ticks(2);
    chk("zw_pc0",   postif_pc_o,   32'hBFC0_0000);
    chk("zw_inst0", postif_inst_o, 32'h403F_FFFF);
    chk("zw_ok0",   32'(postif_inst_ok_o), 32'h1);
    ticks(1);
    chk("zw_stall_wait", 32'(inst_stall_o), 32'h1);
    ticks(1);
    chk("zw_pc1",   postif_pc_o,   32'hBFC0_0004);
    chk("zw_inst1", postif_inst_o, 32'h403F_FFFB);
    ticks(2);
    chk("zw_pc2",   postif_pc_o,   32'hBFC0_0008);

    // Downstream stall at delivery parks the fetch for three cycles.
    ticks(1);
    stall_i = 4'b0100;
    ticks(3);
    chk("hold_req",   32'(inst_req_o),       32'h0);
    chk("hold_ok",    32'(postif_inst_ok_o), 32'h1);
    chk("hold_pc",    postif_pc_o,           32'hBFC0_000C);
    chk("hold_stall", 32'(inst_stall_o),     32'h0);
    stall_i = 4'b0000;
    ticks(1);
    chk("rel_addr", inst_addr_o, 32'hBFC0_0010);
    chk("rel_req",  32'(inst_req_o), 32'h1);

    // Branch while waiting; stale response arrives three cycles after acceptance.
    data_lat = 3;
    ticks(1);
    branch_enable_i = 1; branch_target_i = 32'h8000_1000;
    ticks(1);
    branch_enable_i = 0;
    ticks(2);
    chk("br_addr", inst_addr_o, 32'h8000_1000);
    chk("br_ok",   32'(postif_inst_ok_o), 32'h0);
`ifdef PREIF_FETCH_PERF_EN
    chk("br_squash", perf_squash_cnt_o, 32'd1);
`endif

    // Exception beats branch in the same cycle, before the request is accepted.
    grant_lat = 2; data_lat = 1;
    exception_i = 1; exception_pc_i = 32'hBFC0_0380;
    branch_enable_i = 1; branch_target_i = 32'h8000_2000;
    ticks(1);
    exception_i = 0; branch_enable_i = 0;
    chk("exc_addr", inst_addr_o, 32'hBFC0_0380);
    ticks(3);
    chk("exc_pc",   postif_pc_o,   32'hBFC0_0380);
    chk("exc_inst", postif_inst_o, 32'h403F_FC7F);

    // Branch to a misaligned target during a delivery cycle.
    grant_lat = 0;
    branch_enable_i = 1; branch_target_i = 32'h8000_0002;
    #1;
    chk("redir_valid", 32'(postif_inst_valid_o), 32'h0);
    ticks(1);
    branch_enable_i = 0;
    ticks(1);
    chk("mis_req", 32'(inst_req_o), 32'h0);
    ticks(1);
    chk("mis_ok",    32'(postif_inst_ok_o),    32'h1);
    chk("mis_inst",  postif_inst_o,            32'h0);
    chk("mis_exc",   postif_exception_type_o,  32'h10);
    chk("mis_valid", 32'(postif_inst_valid_o), 32'h1);
    chk("mis_pc",    postif_pc_o,              32'h8000_0002);

    // Recover to the top of the address space; pc wraps to 0.
    branch_enable_i = 1; branch_target_i = 32'hFFFF_FFFC;
    ticks(1);
    branch_enable_i = 0;
    ticks(2);
    chk("wrap_pc",   postif_pc_o,   32'hFFFF_FFFC);
    chk("wrap_inst", postif_inst_o, 32'h0000_0003);
    chk("wrap_addr", inst_addr_o,   32'h0000_0000);

    // Exception redirect out of HOLD.
    ticks(1);
    stall_i = 4'b1000;
    ticks(1);
    exception_i = 1; exception_pc_i = 32'h0000_0100;
    ticks(1);
    exception_i = 0; stall_i = 4'b0000;
    chk("hold_exc_addr", inst_addr_o, 32'h0000_0100);

    // Asynchronous reset in the middle of a wait.
    data_lat = 3;
    ticks(2);
    chk("mid_ren", 32'(postif_inst_ren_o), 32'h1);
    #2 reset_i = 1;
    #1;
    chk("arst_req",   32'(inst_req_o),        32'h0);
    chk("arst_ren",   32'(postif_inst_ren_o), 32'h0);
    chk("arst_ok",    32'(postif_inst_ok_o),  32'h0);
    chk("arst_stall", 32'(inst_stall_o),      32'h1);
    chk("arst_pc",    postif_pc_o,            32'hBFC0_0000);
    chk("arst_inst",  postif_inst_o,          32'h0);
    model_reset();
    data_lat = 1;
    @(negedge clock_i); reset_i = 0;
    @(posedge clock_i); #1;
    chk("post_rst_addr", inst_addr_o, 32'hBFC0_0000);
    ticks(2);
    chk("post_rst_pc", postif_pc_o, 32'hBFC0_0000);
    ticks(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
